// File: rtl/mini16_run_monitor_if.sv
// -----------------------------------------------------------------------------
// mini16_run_monitor_if
// Trace drain port of the mini16 run monitor.
//   trace_valid    : trace FIFO holds at least one entry
//   trace_ready    : consumer accepts the head entry this cycle
//   trace_data     : {timestamp, watched value} at the FIFO head
//   trace_overflow : sticky flag, an entry was dropped because the FIFO was full
// Modports: master = monitor side, slave = host/bench side.
// -----------------------------------------------------------------------------
interface mini16_run_monitor_if #(
  parameter int WIDTH_WATCH = 16,
  parameter int WIDTH_TIME  = 24
);
  logic                              trace_valid;
  logic                              trace_ready;
  logic [WIDTH_TIME+WIDTH_WATCH-1:0] trace_data;
  logic                              trace_overflow;

  modport master (
    output trace_valid,
    output trace_data,
    output trace_overflow,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_data,
    input  trace_overflow,
    output trace_ready
  );
endinterface

// File: rtl/mini16_run_monitor.sv
// -----------------------------------------------------------------------------
// mini16_run_monitor
// Run controller and trace monitor for mini16 SoC bring-up. Sequences the SoC
// reset, bounds the run to MAX_TICKS cycles, stops early on a masked match of
// the watched bus, and timestamps every change of the watched bus into a
// show-ahead trace FIFO drained over a valid/ready port.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   start             : run request (honoured in IDLE and DONE only)
//   watch             : monitored status bus
//   done_value/mask   : completion pattern; zero mask disables matching
//   dut_reset         : reset to the SoC
//   running/finished  : in RUN / in DONE
//   timeout           : DONE was reached because the budget expired
//   cycle_count       : RUN cycle index, holds in DONE
//   trace             : trace FIFO drain port (master modport)
// -----------------------------------------------------------------------------
module mini16_run_monitor #(
  parameter int WIDTH_WATCH  = 16,
  parameter int WIDTH_TIME   = 24,
  parameter int DEPTH_TRACE  = 4,
  parameter int RESET_CYCLES = 10,
  parameter int MAX_TICKS    = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH_WATCH-1:0] watch,
  input  logic [WIDTH_WATCH-1:0] done_value,
  input  logic [WIDTH_WATCH-1:0] done_mask,
  output logic                   dut_reset,
  output logic                   running,
  output logic                   finished,
  output logic                   timeout,
  output logic [WIDTH_TIME-1:0]  cycle_count,
  mini16_run_monitor_if.master   trace
);

  localparam int FIFO_N = 1 << DEPTH_TRACE;
  localparam logic [WIDTH_TIME-1:0]  CNT_ONE   = {{(WIDTH_TIME-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_TIME-1:0]  LAST_TICK = WIDTH_TIME'(MAX_TICKS - 1);
  localparam logic [WIDTH_TIME-1:0]  RST_LOAD  = WIDTH_TIME'(RESET_CYCLES);
  localparam logic [DEPTH_TRACE:0]   PTR_ONE   = {{DEPTH_TRACE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RESET_DUT = 2'd1,
    S_RUN       = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [WIDTH_TIME-1:0]            rst_cnt_q, rst_cnt_d;
  logic [WIDTH_TIME-1:0]            cycle_q, cycle_d;
  logic [WIDTH_WATCH-1:0]           watch_q, watch_d;
  logic                             dut_reset_q, dut_reset_d;
  logic                             running_q, running_d;
  logic                             finished_q, finished_d;
  logic                             timeout_q, timeout_d;
  logic                             valid_q, valid_d;
  logic                             ovf_q, ovf_d;
  logic [DEPTH_TRACE:0]             wr_ptr_q, wr_ptr_d;
  logic [DEPTH_TRACE:0]             rd_ptr_q, rd_ptr_d;
  logic [WIDTH_TIME+WIDTH_WATCH-1:0] mem_q [FIFO_N];

  logic match_s, expire_s, push_s, flush_s;
  logic full_s, pop_s, wr_en_s, drop_s;

  // Run sequencer: next state, counters and registered status outputs.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    flush_s   = 1'b0;
    push_s    = 1'b0;
    watch_d   = watch;
    match_s   = (done_mask != {WIDTH_WATCH{1'b0}}) &&
                ((watch & done_mask) == (done_value & done_mask));
    expire_s  = (cycle_q == LAST_TICK);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RESET_DUT;
          rst_cnt_d = RST_LOAD;
          cycle_d   = {WIDTH_TIME{1'b0}};
          timeout_d = 1'b0;
          flush_s   = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_RESET_DUT: begin
        // Counter was loaded with RESET_CYCLES, so leaving at 1 gives exactly
        // RESET_CYCLES cycles of dut_reset.
        if (rst_cnt_q <= CNT_ONE) begin
          state_d = S_RUN;
          cycle_d = {WIDTH_TIME{1'b0}};
        end else begin
          rst_cnt_d = rst_cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        // cycle_q is zero only in the first RUN cycle: that entry is unconditional.
        push_s = (cycle_q == {WIDTH_TIME{1'b0}}) || (watch != watch_q);
        if (match_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (expire_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_d = cycle_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dut_reset_d = (state_d == S_IDLE) || (state_d == S_RESET_DUT);
    running_d   = (state_d == S_RUN);
    finished_d  = (state_d == S_DONE);
  end

  // Trace FIFO pointer and flag update; a full FIFO still accepts a push when
  // the head is popped in the same cycle.
  always_comb begin
    full_s  = (wr_ptr_q[DEPTH_TRACE] != rd_ptr_q[DEPTH_TRACE]) &&
              (wr_ptr_q[DEPTH_TRACE-1:0] == rd_ptr_q[DEPTH_TRACE-1:0]);
    pop_s   = valid_q && trace.trace_ready;
    wr_en_s = push_s && (!full_s || pop_s);
    drop_s  = push_s && full_s && !pop_s;
    if (flush_s) begin
      wr_ptr_d = {(DEPTH_TRACE+1){1'b0}};
      rd_ptr_d = {(DEPTH_TRACE+1){1'b0}};
      ovf_d    = 1'b0;
    end else begin
      wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s   ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      ovf_d    = ovf_q | drop_s;
    end
    valid_d = (wr_ptr_d != rd_ptr_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= {WIDTH_TIME{1'b0}};
      cycle_q     <= {WIDTH_TIME{1'b0}};
      watch_q     <= {WIDTH_WATCH{1'b0}};
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= {(DEPTH_TRACE+1){1'b0}};
      rd_ptr_q    <= {(DEPTH_TRACE+1){1'b0}};
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cycle_q     <= cycle_d;
      watch_q     <= watch_d;
      dut_reset_q <= dut_reset_d;
      running_q   <= running_d;
      finished_q  <= finished_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Trace storage; contents are meaningless outside the pointer window, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[DEPTH_TRACE-1:0]] <= {cycle_q, watch};
    end
  end

  assign dut_reset            = dut_reset_q;
  assign running              = running_q;
  assign finished             = finished_q;
  assign timeout              = timeout_q;
  assign cycle_count          = cycle_q;
  assign trace.trace_valid    = valid_q;
  assign trace.trace_overflow = ovf_q;
  assign trace.trace_data     = mem_q[rd_ptr_q[DEPTH_TRACE-1:0]];

endmodule

// File: tb/tb_mini16_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_mini16_run_monitor
// Directed bench for mini16_run_monitor with MAX_TICKS=100. Stimulus pushes the
// expected trace entries into a queue; an independent monitor pops and compares
// whenever the DUT hands over an entry (trace_valid & trace_ready).
// -----------------------------------------------------------------------------
module tb_mini16_run_monitor;

  localparam int WW = 16;
  localparam int WT = 24;
  localparam int DT = 4;
  localparam int RC = 10;
  localparam int MT = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [WW-1:0] watch;
  logic [WW-1:0] done_value;
  logic [WW-1:0] done_mask;
  logic          dut_reset;
  logic          running;
  logic          finished;
  logic          timeout;
  logic [WT-1:0] cycle_count;

  mini16_run_monitor_if #(.WIDTH_WATCH(WW), .WIDTH_TIME(WT)) trace_if ();

  mini16_run_monitor #(
    .WIDTH_WATCH(WW), .WIDTH_TIME(WT), .DEPTH_TRACE(DT),
    .RESET_CYCLES(RC), .MAX_TICKS(MT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .watch(watch),
    .done_value(done_value), .done_mask(done_mask),
    .dut_reset(dut_reset), .running(running), .finished(finished),
    .timeout(timeout), .cycle_count(cycle_count), .trace(trace_if)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int n_popped = 0;
  logic [WT+WW-1:0] exp_q [$];
  logic [WW-1:0]    prev_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle: check the index, drive watch, record what must be traced.
  task automatic run_step(input int c, input logic [WW-1:0] w, input bit keep);
    chk("run_cycle_count", 64'(cycle_count), 64'(c));
    chk("run_running", 64'(running), 64'd1);
    chk("run_not_finished", 64'(finished), 64'd0);
    watch = w;
    if ((c == 0 || w != prev_w) && keep) exp_q.push_back({WT'(c), w});
    prev_w = w;
    tick();
  endtask

  // Start a run and walk through the DUT reset phase into RUN cycle 0.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_trace_valid", 64'(trace_if.trace_valid), 64'd0);
    chk("start_overflow", 64'(trace_if.trace_overflow), 64'd0);
    chk("start_timeout", 64'(timeout), 64'd0);
    chk("start_finished", 64'(finished), 64'd0);
    for (int i = 0; i < RC; i++) begin
      chk("rst_dut_high", 64'(dut_reset), 64'd1);
      chk("rst_not_running", 64'(running), 64'd0);
      if (i < RC - 1) tick();
    end
    tick();
    chk("run_entry_dut_reset", 64'(dut_reset), 64'd0);
    chk("run_entry_running", 64'(running), 64'd1);
    chk("run_entry_cycle_count", 64'(cycle_count), 64'd0);
  endtask

  // Wait (bounded) for the monitor to consume every expected entry.
  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_trace_valid", 64'(trace_if.trace_valid), 64'd0);
  endtask

  // Scoreboard monitor: compare each handed-over entry with the queue head.
  initial begin
    logic [WT+WW-1:0] e;
    forever begin
      @(negedge clk);
      if (trace_if.trace_valid === 1'b1 && trace_if.trace_ready === 1'b1) begin
        n_popped++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trace_unexpected: got %0h expected none", trace_if.trace_data);
        end else begin
          e = exp_q.pop_front();
          chk("trace_entry", 64'(trace_if.trace_data), 64'(e));
        end
      end
    end
  end

  // Watchdog bounding the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int base;
    logic [WW-1:0] w;
    reset = 1'b1; start = 1'b0; watch = '0; done_value = '0; done_mask = '0;
    prev_w = '0;
    trace_if.trace_ready = 1'b0;
    repeat (3) tick();
    chk("reset_dut_reset", 64'(dut_reset), 64'd1);
    chk("reset_running", 64'(running), 64'd0);
    chk("reset_finished", 64'(finished), 64'd0);
    chk("reset_timeout", 64'(timeout), 64'd0);
    chk("reset_cycle_count", 64'(cycle_count), 64'd0);
    chk("reset_trace_valid", 64'(trace_if.trace_valid), 64'd0);
    chk("reset_overflow", 64'(trace_if.trace_overflow), 64'd0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_dut_reset", 64'(dut_reset), 64'd1);

    // Trace of 0 / 3@7 / 5@20 with immediate draining, then timeout at 100.
    trace_if.trace_ready = 1'b1;
    do_start();
    for (int c = 0; c < MT; c++) begin
      w = (c < 7) ? 16'h0000 : ((c < 20) ? 16'h0003 : 16'h0005);
      run_step(c, w, 1'b1);
      if (c <= 25) chk("trace_valid_latency", 64'(trace_if.trace_valid),
                       64'((c == 0 || c == 7 || c == 20) ? 1 : 0));
    end
    chk("to_finished", 64'(finished), 64'd1);
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_running", 64'(running), 64'd0);
    chk("to_cycle_count", 64'(cycle_count), 64'd99);
    chk("to_dut_reset", 64'(dut_reset), 64'd0);
    wait_drain();
    chk("trace_entry_count", 64'(n_popped), 64'd3);

    // Match at run cycle 42.
    done_mask = 16'h000F; done_value = 16'h0009;
    do_start();
    for (int c = 0; c <= 42; c++) run_step(c, (c == 42) ? 16'hA509 : 16'h0000, 1'b1);
    chk("match_finished", 64'(finished), 64'd1);
    chk("match_timeout", 64'(timeout), 64'd0);
    chk("match_cycle_count", 64'(cycle_count), 64'd42);
    chk("match_dut_reset", 64'(dut_reset), 64'd0);
    wait_drain();

    // Match coinciding with the last budget cycle counts as a match.
    do_start();
    for (int c = 0; c < MT; c++) run_step(c, (c == MT - 1) ? 16'hA509 : 16'h0000, 1'b1);
    chk("late_match_finished", 64'(finished), 64'd1);
    chk("late_match_timeout", 64'(timeout), 64'd0);
    chk("late_match_cycle_count", 64'(cycle_count), 64'd99);
    wait_drain();

    // Overflow: 20 changes with no draining, only the first 16 survive.
    done_mask = 16'h0000;
    trace_if.trace_ready = 1'b0;
    base = n_popped;
    do_start();
    w = 16'h0000;
    for (int c = 0; c < 20; c++) begin
      w = 16'h0100 + c[15:0];
      run_step(c, w, (c < 16) ? 1'b1 : 1'b0);
    end
    chk("ovf_flag", 64'(trace_if.trace_overflow), 64'd1);
    chk("ovf_valid", 64'(trace_if.trace_valid), 64'd1);
    trace_if.trace_ready = 1'b1;
    for (int c = 20; c < MT; c++) run_step(c, w, 1'b1);
    chk("ovf_timeout", 64'(timeout), 64'd1);
    wait_drain();
    chk("ovf_kept_count", 64'(n_popped - base), 64'd16);
    chk("ovf_sticky", 64'(trace_if.trace_overflow), 64'd1);

    // Full FIFO with push and pop in the same cycle: nothing dropped.
    trace_if.trace_ready = 1'b0;
    base = n_popped;
    do_start();
    for (int c = 0; c < 16; c++) run_step(c, 16'h0200 + c[15:0], 1'b1);
    trace_if.trace_ready = 1'b1;
    run_step(16, 16'h0300, 1'b1);
    trace_if.trace_ready = 1'b0;
    chk("full_pp_overflow", 64'(trace_if.trace_overflow), 64'd0);
    chk("full_pp_valid", 64'(trace_if.trace_valid), 64'd1);
    trace_if.trace_ready = 1'b1;
    for (int c = 17; c <= 40; c++) run_step(c, 16'h0300, 1'b1);
    chk("full_pp_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("full_pp_count", 64'(n_popped - base), 64'd17);
    chk("full_pp_overflow_end", 64'(trace_if.trace_overflow), 64'd0);

    // start is ignored while running.
    start = 1'b1;
    run_step(41, 16'h0300, 1'b1);
    start = 1'b0;
    run_step(42, 16'h0300, 1'b1);

    // Mid-run reset discards the pending trace entry.
    trace_if.trace_ready = 1'b0;
    run_step(43, 16'h0400, 1'b1);
    chk("pre_reset_valid", 64'(trace_if.trace_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("mid_reset_dut_reset", 64'(dut_reset), 64'd1);
    chk("mid_reset_running", 64'(running), 64'd0);
    chk("mid_reset_valid", 64'(trace_if.trace_valid), 64'd0);
    chk("mid_reset_cycle_count", 64'(cycle_count), 64'd0);
    repeat (3) tick();
    chk("idle_after_reset_dut_reset", 64'(dut_reset), 64'd1);
    chk("idle_after_reset_valid", 64'(trace_if.trace_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mini16_run_monitor.md
# mini16_run_monitor

Synthesizable run controller and trace monitor for mini16 SoC bring-up, in both simulation and on hardware. It sequences the DUT reset and bounds the run to a cycle budget. It timestamps every change on a watched status bus (e.g. `led`) into a trace FIFO that a host or bench drains over a valid/ready port. It sits between the board or bench clock/reset and the SoC's `reset` input. The watched bus connects to SoC status outputs.

## Interface
- `WIDTH_WATCH`, 16: watched bus width.
- `WIDTH_TIME`, 24: timestamp and cycle counter width; `MAX_TICKS < 2**WIDTH_TIME`.
- `DEPTH_TRACE`, 4: log2 of trace FIFO entries (16).
- `RESET_CYCLES`, 10: DUT reset pulse length, ≥1.
- `MAX_TICKS`, 10000: run budget in cycles, ≥1.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: run request; sampled only in IDLE and DONE.
- `watch`  in  WIDTH_WATCH: monitored bus, synchronous to `clk`.
- `done_value`  in  WIDTH_WATCH: completion pattern.
- `done_mask`  in  WIDTH_WATCH: completion mask; all-zero disables matching.
- `dut_reset`  out  1: reset to the SoC.
- `running`  out  1: high in RUN.
- `finished`  out  1: high in DONE.
- `timeout`  out  1: high in DONE when the budget expired.
- `cycle_count`  out  WIDTH_TIME: RUN cycle index.
- `trace_valid`  out  1: FIFO non-empty.
- `trace_ready`  in  1: consumer pop.
- `trace_data`  out  WIDTH_TIME+WIDTH_WATCH: `{timestamp, value}` at FIFO head.
- `trace_overflow`  out  1: sticky, set when an entry was dropped.

## Operation
- States: IDLE, RESET_DUT, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, `dut_reset`=1, all other outputs 0, FIFO empty.
- IDLE: `dut_reset`=1. `start` moves to RESET_DUT, clears the FIFO, `trace_overflow` and `timeout`, and loads the down-counter with RESET_CYCLES.
- RESET_DUT: `dut_reset`=1 for exactly RESET_CYCLES cycles, then go to RUN with `cycle_count`=0.
- RUN: `dut_reset`=0, `running`=1, `cycle_count` increments by 1 per cycle.
  - First RUN cycle: unconditionally push `{0, watch}`.
  - Later cycles: push `{cycle_count, watch}` when `watch` differs from its value in the previous cycle.
  - Match when `done_mask`≠0 and `(watch & done_mask) == (done_value & done_mask)`; go to DONE with `timeout`=0.
  - Otherwise, if `cycle_count == MAX_TICKS-1`, go to DONE with `timeout`=1.
  - A match and expiry in the same cycle count as a match (`timeout`=0).
  - A change in the final RUN cycle is still traced.
- DONE: `finished`=1, `dut_reset` stays 0 so the SoC state remains inspectable, `cycle_count` holds. The FIFO stays drainable. `start` restarts as from IDLE.
- `start` is ignored in RESET_DUT and RUN.
- FIFO: show-ahead, 2**DEPTH_TRACE entries, pop on `trace_valid & trace_ready`.
  - Push while full with no pop: entry dropped, `trace_overflow` set.
  - Push and pop in the same cycle while full: both succeed.
  - Pop while empty: ignored.
- `reset` in any state: all reset values next cycle, and trace contents are discarded.

## Timing
- `start` sampled at edge N: RESET_DUT from N+1; `dut_reset` high through cycle N+RESET_CYCLES; RUN from cycle N+1+RESET_CYCLES with `dut_reset`=0 and `cycle_count`=0.
- Push in cycle t makes `trace_valid` and `trace_data` visible in cycle t+1 (if the FIFO was empty).
- Match evaluated in RUN cycle t gives `finished` in cycle t+1; `running` drops in the same cycle.
- Timeout run length is exactly MAX_TICKS cycles: `finished`=`timeout`=1 in the cycle after `cycle_count`=MAX_TICKS-1.
- Pop throughput: one entry per cycle.

## Test plan
- Reset sequence, RESET_CYCLES=10: reset, then `start` pulse at cycle 5 -> `dut_reset` high cycles 6–15, low at 16; `running`=1 and `cycle_count`=0 at 16.
- Trace, `trace_ready`=1, `done_mask`=0: `watch` = 0 at run start, 3 at run cycle 7, 5 at run cycle 20 -> entries {0,0}, {7,3}, {20,5}, in order, each one cycle after its push.
- Timeout, MAX_TICKS=100, `done_mask`=0: run -> `finished`=`timeout`=1 exactly 100 cycles after RUN entry; `cycle_count` holds 99; `dut_reset` stays 0.
- Done match, `done_mask`=16'h000F, `done_value`=16'h0009: `watch`=16'hA509 at run cycle 42 -> `finished`=1, `timeout`=0 at cycle 43. Same pattern at cycle MAX_TICKS-1 -> `timeout`=0.
- Overflow, DEPTH_TRACE=4, `trace_ready`=0: `watch` toggles every cycle for 20 cycles -> 16 entries kept (first 16), `trace_overflow`=1. A later `start` clears it.
- Full-FIFO push/pop and mid-run reset: FIFO full with `trace_ready`=1 and a change in the same cycle -> count stays 16, no overflow. `reset` in RUN -> next cycle IDLE, `dut_reset`=1, `trace_valid`=0.
